// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: transmit FSM state enum, register word offsets (a[7:2]),
// STATUS bit positions, and the parity-build flag.
// Build option: define UART_TX_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Word offsets within the 256-byte window (byte offsets 0x00, 0x04, 0x08).
    localparam logic [5:0] OFF_TXDATA  = 6'h00;
    localparam logic [5:0] OFF_STATUS  = 6'h01;
    localparam logic [5:0] OFF_BAUDDIV = 6'h02;

    // STATUS bit positions.
    localparam int unsigned STS_BUSY    = 0;
    localparam int unsigned STS_FULL    = 1;
    localparam int unsigned STS_EMPTY   = 2;
    localparam int unsigned STS_OVR     = 3;
    localparam int unsigned STS_CNT_LSB = 4;   // 5-bit fifo count in [8:4]
    localparam int unsigned STS_PAR     = 9;

`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with combinational read of the head entry.
// Latency: a push is visible at dout/empty the cycle after the push edge.
// Backpressure: push is dropped when full unless a pop happens in the same cycle.
//
// Ports: clk, reset (sync, active-high); push/din write side; pop/dout read
// side (dout shows the head entry); full, empty, count status.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    // A simultaneous pop frees the slot, so a push while full is still taken.
    // When full, wr_ptr == rd_ptr: the head is read out this cycle and the
    // slot is overwritten at the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the MIPS data bus with a small TX FIFO.
// Latency: reads combinational; push at edge N pops at N+1, start bit from N+1.
// Backpressure: none on the bus; a push into a full FIFO is dropped and flags overrun.
//
// Ports: clk, reset (sync, active-high); we/a/wd CPU write strike, address,
// data; rd combinational read data (0 when not selected); sel window hit;
// txd serial output (idle high, registered).
// Build option: UART_TX_PARITY_EN adds an even-parity bit after the data bits.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE      = 32'hFFFF_FF00,
    parameter int          DEPTH     = 4,
    parameter logic [15:0] DIV_RESET = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        sel,
    output logic        txd
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [5:0]    off;
    logic          wr_txdata;
    logic          wr_status;
    logic          wr_baud;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic [15:0]   div;
    logic          overrun;

    uart_state_t   state, state_nxt;
    logic [15:0]   bit_cnt, bit_cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shifter, shifter_nxt;
    logic          txd_nxt;
`ifdef UART_TX_PARITY_EN
    logic          par, par_nxt;
`endif

    // Address bits that never take part in decode.
    logic unused_bits;
    assign unused_bits = ^{a[1:0], wd[31:16]};

    assign sel       = (a[31:8] == BASE[31:8]);
    assign off       = a[7:2];
    assign wr_txdata = we && sel && (off == OFF_TXDATA);
    assign wr_status = we && sel && (off == OFF_STATUS);
    assign wr_baud   = we && sel && (off == OFF_BAUDDIV);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .din   (wd[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Divisor and sticky overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            div     <= DIV_RESET;
            overrun <= 1'b0;
        end else begin
            // A zero divisor would never end a bit, so it is clamped to 1.
            if (wr_baud) div <= (wd[15:0] == 16'd0) ? 16'd1 : wd[15:0];
            if (wr_txdata && fifo_full && !fifo_pop)
                overrun <= 1'b1;
            else if (wr_status && wd[STS_OVR])
                overrun <= 1'b0;
        end
    end

    // Transmit FSM: next state, datapath next values and the pop strobe.
    // bit_cnt is reloaded from div at every bit boundary, so a divisor
    // change lands on the next bit rather than stretching the current one.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = (bit_cnt != 16'd0) ? bit_cnt - 16'd1 : 16'd0;
        bit_idx_nxt = bit_idx;
        shifter_nxt = shifter;
        fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_nxt     = par;
`endif
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    shifter_nxt = fifo_dout;
                    bit_cnt_nxt = div - 16'd1;
                    state_nxt   = ST_START;
`ifdef UART_TX_PARITY_EN
                    par_nxt     = ^fifo_dout;
`endif
                end
            end
            ST_START: begin
                if (bit_cnt == 16'd0) begin
                    bit_cnt_nxt = div - 16'd1;
                    bit_idx_nxt = 3'd0;
                    state_nxt   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_cnt == 16'd0) begin
                    bit_cnt_nxt = div - 16'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = ST_PARITY;
`else
                        state_nxt = ST_STOP;
`endif
                    end else begin
                        shifter_nxt = {1'b0, shifter[7:1]};
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_cnt == 16'd0) begin
                    bit_cnt_nxt = div - 16'd1;
                    state_nxt   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_cnt == 16'd0) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase

        // txd is registered; decode it from the state being entered so the
        // line changes on the same edge as the state.
        case (state_nxt)
            ST_START: txd_nxt = 1'b0;
            ST_DATA:  txd_nxt = shifter_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: txd_nxt = par_nxt;
`endif
            default:  txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            bit_cnt <= 16'd0;
            bit_idx <= 3'd0;
            shifter <= 8'd0;
            txd     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shifter <= shifter_nxt;
            txd     <= txd_nxt;
`ifdef UART_TX_PARITY_EN
            par     <= par_nxt;
`endif
        end
    end

    // Combinational read port, muxed against RAM at the top level.
    always_comb begin
        rd = 32'd0;
        if (sel) begin
            case (off)
                OFF_STATUS: begin
                    rd[STS_BUSY]           = (state != ST_IDLE);
                    rd[STS_FULL]           = fifo_full;
                    rd[STS_EMPTY]          = fifo_empty;
                    rd[STS_OVR]            = overrun;
                    rd[STS_CNT_LSB +: 5]   = 5'(fifo_count);
                    rd[STS_PAR]            = PARITY_EN;
                end
                OFF_BAUDDIV: rd[15:0] = div;
                default: rd = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: bus register checks, cycle-exact
// frame checks, and a serial monitor that decodes txd against a byte queue.
// Build option mirrored from the design: UART_TX_PARITY_EN.
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TX = 32'hFFFF_FF00;
    localparam logic [31:0] A_ST = 32'hFFFF_FF04;
    localparam logic [31:0] A_BD = 32'hFFFF_FF08;
`ifdef UART_TX_PARITY_EN
    localparam int   NBITS = 11;
    localparam logic PAR   = 1'b1;
`else
    localparam int   NBITS = 10;
    localparam logic PAR   = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic        we    = 1'b0;
    logic [31:0] a     = A_ST;
    logic [31:0] wd    = 32'd0;
    logic [31:0] rd;
    logic        sel;
    logic        txd;

    int          total   = 0;
    int          bad     = 0;
    logic [7:0]  exp_q[$];
    int          cur_div = 434;
    bit          mon_en  = 1'b1;

    mmio_uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .a     (a),
        .wd    (wd),
        .rd    (rd),
        .sel   (sel),
        .txd   (txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected line level for bit slot j of a frame carrying b.
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (NBITS == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        we = 1'b1; a = addr; wd = data;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] addr, output logic [31:0] v);
        a = addr;
        #1;
        v = rd;
    endtask

    task automatic wait_drain(input int budget);
        logic [31:0] v;
        int n;
        v = 32'd1;
        n = 0;
        while (n < budget && (exp_q.size() != 0 || v[0] != 1'b0)) begin
            @(negedge clk);
            rd_reg(A_ST, v);
            n++;
        end
        chk("drain_queue", exp_q.size(), 0);
        rd_reg(A_ST, v);
        chk("drain_status", v, 32'h4);
    endtask

    // Serial monitor: txd low at a negedge marks the first cycle of a start
    // bit; each later bit is sampled mid-period.
    task automatic decode_frame();
        int         d;
        logic [7:0] b;
        logic [7:0] e;
        d = cur_div;
        b = 8'd0;
        repeat (d / 2) @(negedge clk);
        chk("mon_start", txd, 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (d) @(negedge clk);
            b[i] = txd;
        end
        chk("mon_pending", exp_q.size() > 0, 1'b1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk("mon_byte", b, e);
`ifdef UART_TX_PARITY_EN
        repeat (d) @(negedge clk);
        chk("mon_parity", txd, ^e);
`endif
        repeat (d) @(negedge clk);
        chk("mon_stop", txd, 1'b1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !reset && txd === 1'b0) decode_frame();
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        bit          found;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd_reg(A_ST, v);
        chk("rst_status", v, 32'h4);
        chk("rst_sel", sel, 1'b1);
        chk("rst_txd", txd, 1'b1);
        rd_reg(A_BD, v);
        chk("rst_div", v, 32'd434);

        // Zero divisor clamps to 1
        bus_write(A_BD, 32'd0);
        rd_reg(A_BD, v);
        chk("div_zero", v, 32'd1);

        // Single frame at divisor 4, checked every cycle
        bus_write(A_BD, 32'd4);
        cur_div = 4;
        rd_reg(A_BD, v);
        chk("div_four", v, 32'd4);
        exp_q.push_back(8'hA5);
        bus_write(A_TX, 32'hA5);
        chk("a5_pre_start", txd, 1'b1);
        for (int k = 0; k < NBITS * 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("a5_cyc%0d", k), txd, frame_bit(8'hA5, k / 4));
        end
        @(posedge clk);
        #1;
        rd_reg(A_ST, v);
        chk("a5_idle_status", v, 32'h4);

        // Burst of 6 at divisor 2: 5 accepted, 6th overruns
        bus_write(A_BD, 32'd2);
        cur_div = 2;
        @(negedge clk);
        we = 1'b1;
        a  = A_TX;
        for (int i = 0; i < 6; i++) begin
            b  = 8'(i * 37 + 11);
            wd = {24'd0, b};
            if (i < 5) exp_q.push_back(b);
            @(negedge clk);
        end
        we = 1'b0;
        rd_reg(A_ST, v);
        chk("burst_overrun_status", v, 32'h4B);
        bus_write(A_ST, 32'h8);
        rd_reg(A_ST, v);
        chk("w1c_status", v, 32'h43);

        // Push on the very edge the FSM pops from the full FIFO
        found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            rd_reg(A_ST, v);
            if (v[0] == 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        chk("pop_window_found", found, 1'b1);
        we = 1'b1; a = A_TX; wd = 32'hC3;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        we = 1'b0;
        rd_reg(A_ST, v);
        chk("push_pop_full_status", v, 32'h43);
        wait_drain(600);

        // Random bytes at divisor 3
        bus_write(A_BD, 32'd3);
        cur_div = 3;
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            bus_write(A_TX, {24'd0, b});
        end
        wait_drain(800);

        // Accesses outside the window or to unmapped offsets
        bus_write(32'h0000_0008, 32'd0);
        bus_write(32'h0000_0000, 32'h55);
        bus_write(32'h0000_0040, 32'hFFFF_FFFF);
        bus_write(32'hFFFF_FF0C, 32'd0);
        rd_reg(32'h0000_0040, v);
        chk("outside_sel", sel, 1'b0);
        chk("outside_rd", v, 32'd0);
        rd_reg(32'h0000_0008, v);
        chk("outside_alias_rd", v, 32'd0);
        rd_reg(32'hFFFF_FF10, v);
        chk("unmapped_sel", sel, 1'b1);
        chk("unmapped_rd", v, 32'd0);
        rd_reg(A_BD, v);
        chk("window_div_kept", v, 32'd3);
        rd_reg(A_ST, v);
        chk("window_status_kept", v, 32'h4);
        repeat (40) @(negedge clk);
        chk("window_no_frame", txd, 1'b1);

        // Reset in the middle of the data bits
        bus_write(A_BD, 32'd4);
        cur_div = 4;
        mon_en  = 1'b0;
        bus_write(A_TX, 32'h00);
        repeat (7) @(negedge clk);
        rd_reg(A_ST, v);
        chk("mid_frame_status", v, 32'h5);
        chk("mid_frame_txd", txd, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_reset_txd", txd, 1'b1);
        rd_reg(A_ST, v);
        chk("post_reset_status", v, 32'h4);
        rd_reg(A_BD, v);
        chk("post_reset_div", v, 32'd434);
        repeat (50) @(negedge clk);
        chk("post_reset_quiet", txd, 1'b1);
        cur_div = 434;
        mon_en  = 1'b1;

        // Parity flag and a 0x07 frame at divisor 2
        bus_write(A_BD, 32'd2);
        cur_div = 2;
        rd_reg(A_ST, v);
        chk("par_flag", v[9], PAR);
        exp_q.push_back(8'h07);
        bus_write(A_TX, 32'h07);
        chk("b07_pre_start", txd, 1'b1);
        for (int k = 0; k < NBITS * 2; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("b07_cyc%0d", k), txd, frame_bit(8'h07, k / 2));
        end
        @(posedge clk);
        #1;
        rd_reg(A_ST, v);
        chk("b07_idle_status", v, {22'd0, PAR, 9'h004});
        wait_drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the multicycle MIPS data bus, alongside the word-addressed RAM. Decodes its own address window from the CPU's adr/writedata/memwrite signals and queues bytes in a small FIFO. Shifts the bytes out serially (8N1) on txd. Presents a combinational read port and a hit flag so the top level can mux its readdata against RAM's.

## Interface
- BASE, 32'hFFFF_FF00: base address of the 256-byte register window; a[31:8] must match BASE[31:8].
- DEPTH, 4: TX FIFO entries; power of two, 2..16.
- DIV_RESET, 16'd434: reset value of the baud divisor (clock cycles per bit).
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  bus write strike (the CPU's memwrite).
- a  input  32  bus byte address.
- wd  input  32  bus write data.
- rd  output  32  register read data; combinational; 0 when sel=0.
- sel  output  1  combinational; 1 when a[31:8]==BASE[31:8].
- txd  output  1  serial line; idle high.

## Operation
- Registers, decoded on a[7:2]; other offsets read 0 and ignore writes:
  - 0x00 TXDATA: write pushes wd[7:0]; reads 0.
  - 0x04 STATUS: read-only fields plus a W1C bit.
    - bit0 busy: FSM not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overrun: sticky, W1C.
    - bits[8:4] fifo count.
  - 0x08 BAUDDIV: R/W in bits[15:0]; writing 0 stores 1.
- A push when full drops the byte and sets overrun.
- A push and a pop in the same cycle are both honoured, including when full; overrun stays unchanged.
- Transmit FSM states:
  - IDLE: txd=1. If the FIFO is not empty, pop, latch the byte into the shifter, go to START.
  - START: txd=0 for one bit period.
  - DATA: txd=shifter[0], LSB first, 8 bit periods.
  - PARITY: only with the Configuration macro.
  - STOP: txd=1 for one bit period, then IDLE.
- Bit-period counter:
  - Loads BAUDDIV-1 on entry to each bit.
  - Decrements each cycle; the bit ends at count 0.
  - A BAUDDIV write mid-frame takes effect at the next bit boundary.
- Reset, including mid-frame: state IDLE, txd=1, FIFO empty, count 0, overrun 0, BAUDDIV=DIV_RESET. Any in-flight byte is abandoned.

## Timing
- Bus reads are zero-latency combinational, like RAM.
- Writes register on the posedge with we=1 and sel=1.
- Push at edge N:
  - The pop and START entry occur at edge N+1.
  - txd falls in the cycle following edge N+1.
- Frame length is 10×BAUDDIV cycles; 11×BAUDDIV with parity.
- Back-to-back frames: IDLE lasts exactly one cycle between STOP and the next START when the FIFO is non-empty.

## Configuration
- UART_TX_PARITY_EN defined:
  - PARITY state inserted after DATA, driving the even-parity bit (XOR of the 8 data bits) for one bit period.
  - STATUS bit9 reads 1.
- Undefined: no PARITY state, 8N1 framing, STATUS bit9 reads 0.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - register offset constants (TXDATA, STATUS, BAUDDIV);
  - STATUS bit index constants.
- Sub-module sync_fifo (parameter WIDTH=8, DEPTH; ports push, pop, din, dout, full, empty, count) holds the FIFO storage and pointers. Same clk and synchronous active-high reset.
- The bus decode, registers, divisor and FSM stay in mmio_uart_tx.

## Test plan
- Reset, then read 0x...04: rd=32'h4 (empty), txd=1, sel=1. Read 0x...08: rd=434.
- Write BAUDDIV=4, then TXDATA=8'hA5: txd falls one cycle after the next edge, then carries bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1. Total 40 cycles; busy clears afterwards.
- BAUDDIV=2; write 5 bytes back-to-back with DEPTH=4. The first is popped immediately, so all 5 are accepted. A 6th write while full sets overrun: STATUS bit3=1. Writing STATUS=8 clears it.
- Push on the exact cycle the FSM pops from a full FIFO: count stays 4, overrun stays 0, all bytes transmitted in order.
- Assert reset for one cycle mid-DATA: next cycle txd=1, STATUS=32'h4, BAUDDIV=434.
- With UART_TX_PARITY_EN, send 8'h07 at BAUDDIV=2: parity bit=1, frame 22 cycles, STATUS bit9=1. Access to 0x0000_0040: sel=0, rd=0, no register changes.
